// File: rtl/inst_encode_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_encode_loader_pkg
// Desc   : RV32I opcode constants and loader state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package inst_encode_loader_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } load_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_field_pack.sv
`default_nettype none
// ============================================================================
// Module : inst_field_pack
// Desc   : Packs RV32I fields into an instruction word and flags illegal bundles.
// Rev    : 1.0  initial release
// ============================================================================
module inst_field_pack
   import inst_encode_loader_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        reject
);

   logic w_imm12_ok;
   logic w_imm13_ok;
   logic w_imm21_ok;
   logic w_upper_ok;

   // An immediate fits an N-bit signed field when every bit above its sign bit copies it.
   assign w_imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
   assign w_imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign w_imm21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
   assign w_upper_ok = ~(|imm[11:0]);

   always_comb begin
      word   = '0;
      reject = 1'b0;
      case (opcode)
         OP_R: begin
            word = {func7, rs2, rs1, func3, rd, opcode};
         end
         OP_I_ALU, OP_LOAD, OP_JALR: begin
            word   = {imm[11:0], rs1, func3, rd, opcode};
            reject = ~w_imm12_ok;
         end
         OP_STORE: begin
            word   = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            reject = ~w_imm12_ok;
         end
         OP_BRANCH: begin
            word   = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            reject = ~w_imm13_ok;
         end
         OP_AUIPC, OP_LUI: begin
            word   = {imm[31:12], rd, opcode};
            reject = ~w_upper_ok;
         end
         OP_JAL: begin
            word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            reject = ~w_imm21_ok;
         end
         default: begin
            reject = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module : inst_encode_loader
// Desc   : Session-based loader writing encoded RV32I words into instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
module inst_encode_loader
   import inst_encode_loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        finish,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        err,
   output logic        done,
   output logic [10:0] count
);

   localparam logic [11:0] DEPTH_W = 12'(DEPTH);

   load_state_t state_q, state_d;
   logic [10:0] count_q, count_d;
   logic        mem_we_q, mem_we_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic [31:0] w_word;
   logic        w_reject;
   logic [11:0] w_issued;
   logic        w_accept;

   inst_field_pack u_pack (
      .opcode (opcode),
      .func3  (func3),
      .func7  (func7),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .imm    (imm),
      .word   (w_word),
      .reject (w_reject)
   );

   // The write on the bus right now is not yet in count, so it still occupies a slot.
   assign w_issued = {1'b0, count_q} + {11'd0, mem_we_q};
   assign in_ready = (state_q == ST_LOAD) && (w_issued < DEPTH_W);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      mem_we_d    = 1'b0;
      err_d       = 1'b0;
      done_d      = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (w_accept) begin
         if (w_reject) begin
            err_d = 1'b1;
         end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {18'd0, w_issued, 2'b00};
            mem_wdata_d = w_word;
         end
      end

      if (mem_we_q) begin
         count_d = count_q + 11'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               count_d = '0;
            end
         end
         ST_LOAD: begin
            if (finish) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (mem_we_q && (({1'b0, count_q} + 12'd1) == DEPTH_W)) begin
               state_d = ST_FULL;
               done_d  = 1'b1;
            end
         end
         ST_FULL: begin
            if (finish) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         mem_we_q    <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         mem_we_q    <= mem_we_d;
         err_q       <= err_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign err       = err_q;
   assign done      = done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_encode_loader
// Desc   : Self-checking bench for inst_encode_loader against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_encode_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int K_BAD = -1, K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_U = 4, K_J = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic [6:0]  opcode = '0, func7 = '0;
   logic [2:0]  func3 = '0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic [31:0] imm = '0;
   logic        in_ready, mem_we, err, done;
   logic [31:0] mem_addr, mem_wdata;
   logic [10:0] count;

   int vectors = 0, miscompares = 0;

   // Behavioural model: session mode (0 idle, 1 accepting, 2 full), good bundles
   // accepted this session, words landed, and the outputs expected right now.
   int          m_mode = 0, m_accepted = 0, m_count = 0;
   logic        exp_we = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
   logic [31:0] exp_addr = BASE, exp_data = '0;

   inst_encode_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .func3(func3), .func7(func7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .err(err), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   function automatic int op_kind(input logic [6:0] op);
      case (op)
         7'b0110011:                         return K_R;
         7'b0010011, 7'b0000011, 7'b1100111: return K_I;
         7'b0100011:                         return K_S;
         7'b1100011:                         return K_B;
         7'b0010111, 7'b0110111:             return K_U;
         7'b1101111:                         return K_J;
         default:                            return K_BAD;
      endcase
   endfunction

   function automatic bit ref_legal(input logic [6:0] op, input logic [31:0] im);
      int s;
      s = int'($signed(im));
      case (op_kind(op))
         K_R:      return 1'b1;
         K_I, K_S: return (s >= -2048) && (s <= 2047);
         K_B:      return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
         K_J:      return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
         K_U:      return (im % 4096) == 0;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] a,
                                              input logic [4:0] b, input logic [4:0] d,
                                              input logic [31:0] im);
      int unsigned u, o, r1, r2, rdv, base;
      u = im; o = 32'(op); r1 = 32'(a); r2 = 32'(b); rdv = 32'(d);
      base = o + 32'(f3) * 4096 + r1 * 32768;
      case (op_kind(op))
         K_R: return base + rdv * 128 + r2 * 1048576 + 32'(f7) * 33554432;
         K_I: return base + rdv * 128 + (u % 4096) * 1048576;
         K_S: return base + r2 * 1048576 + (u % 32) * 128 + ((u / 32) % 128) * 33554432;
         K_B: return base + r2 * 1048576 + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256
                     + ((u / 32) % 64) * 33554432 + ((u / 4096) % 2) * 32'h8000_0000;
         K_U: return o + rdv * 128 + (u / 4096) * 4096;
         K_J: return o + rdv * 128 + ((u / 4096) % 256) * 4096 + ((u / 2048) % 2) * 1048576
                     + ((u / 2) % 1024) * 2097152 + ((u / 1048576) % 2) * 32'h8000_0000;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit exp_ready();
      return (m_mode == 1) && (m_accepted < DEPTH);
   endfunction

   function automatic logic [31:0] pick_imm();
      logic [31:0] edges [12];
      edges = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF, 32'd4094, 32'hFFFF_F000,
                32'd4095, 32'd4096, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000, 32'd1};
      case ($urandom_range(0, 4))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       return edges[$urandom_range(0, 11)];
         3:       return 32'($signed($urandom) >>> 11);
         default: return $urandom & 32'hFFFF_F000;
      endcase
   endfunction

   task automatic rand_bundle();
      logic [6:0] ops [9];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};
      opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      func3 = 3'($urandom); func7 = 7'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      imm = pick_imm();
   endtask

   task automatic set_bundle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             input logic [31:0] im);
      opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; rd = d; imm = im;
      in_valid = 1'b1;
   endtask

   // Applies the current inputs across one clock edge and moves the model with it.
   task automatic advance();
      bit acc;
      int nmode, ncount;
      logic nwe, nerr, ndone;
      logic [31:0] naddr, ndata;
      acc = in_valid && exp_ready();
      nwe = 1'b0; nerr = 1'b0; ndone = 1'b0;
      naddr = exp_addr; ndata = exp_data;
      ncount = exp_we ? m_count + 1 : m_count;
      nmode = m_mode;
      if (acc) begin
         if (ref_legal(opcode, imm)) begin
            nwe = 1'b1;
            naddr = BASE + 32'(4 * m_accepted);
            ndata = ref_encode(opcode, func3, func7, rs1, rs2, rd, imm);
            m_accepted++;
         end else begin
            nerr = 1'b1;
         end
      end
      if (m_mode == 0) begin
         if (start) begin nmode = 1; ncount = 0; m_accepted = 0; end
      end else if (m_mode == 1) begin
         if (finish) begin nmode = 0; ndone = 1'b1; end
         else if (exp_we && (m_count + 1 == DEPTH)) begin nmode = 2; ndone = 1'b1; end
      end else if (finish) begin
         nmode = 0;
      end
      if (rst) begin
         nmode = 0; ncount = 0; m_accepted = 0;
         nwe = 1'b0; nerr = 1'b0; ndone = 1'b0; naddr = BASE; ndata = '0;
      end
      @(posedge clk);
      #1;
      m_mode = nmode; m_count = ncount;
      exp_we = nwe; exp_err = nerr; exp_done = ndone; exp_addr = naddr; exp_data = ndata;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      set_bundle(7'b0110011, 3'd0, 7'd0, 5'd2, 5'd3, 5'd1, 32'd0);
      advance();
      advance();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      vectors++;
      if (mem_we !== 1'b0 || err !== 1'b0 || done !== 1'b0 || count !== 11'd0 ||
          mem_addr !== BASE || mem_wdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state we=%b err=%b done=%b count=%0d addr=%h data=%h, required all zero, addr=%h",
                  mem_we, err, done, count, mem_addr, mem_wdata, BASE);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b required 0", in_ready);
      end
   endtask

   task automatic test_encode_directed();
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0110011, 3'd0, 7'd0, 5'd2, 5'd3, 5'd1, 32'd0);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL load_in_ready got %b required 1", in_ready);
      end
      advance();
      in_valid = 1'b0; finish = 1'b1;
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h003100B3) begin
         miscompares++;
         $display("FAIL r_add we=%b addr=%h data=%h required 1 00000000 003100b3", mem_we, mem_addr, mem_wdata);
      end
      advance(); finish = 1'b0;
      vectors++;
      if (done !== 1'b1 || count !== 11'd1 || mem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL finish_done done=%b count=%0d we=%b required 1 1 0", done, count, mem_we);
      end
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
      advance();
      set_bundle(7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hFFF00293 || count !== 11'd0) begin
         miscompares++;
         $display("FAIL addi we=%b addr=%h data=%h count=%0d required 1 0 fff00293 0", mem_we, mem_addr, mem_wdata, count);
      end
      advance();
      in_valid = 1'b0;
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hFE208EE3) begin
         miscompares++;
         $display("FAIL beq we=%b addr=%h data=%h required 1 4 fe208ee3", mem_we, mem_addr, mem_wdata);
      end
      finish = 1'b1; advance(); finish = 1'b0;
      vectors++;
      if (done !== 1'b1 || count !== 11'd2 || mem_wdata !== 32'hFE208EE3) begin
         miscompares++;
         $display("FAIL b2b_done done=%b count=%0d data=%h required 1 2 fe208ee3", done, count, mem_wdata);
      end
   endtask

   task automatic test_reject();
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd1, 32'd2048);
      advance();
      set_bundle(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd1, 32'd0);
      vectors++;
      if (err !== 1'b1 || mem_we !== 1'b0 || count !== 11'd0) begin
         miscompares++;
         $display("FAIL reject_imm err=%b we=%b count=%0d required 1 0 0", err, mem_we, count);
      end
      advance();
      in_valid = 1'b0;
      vectors++;
      if (err !== 1'b1 || mem_we !== 1'b0 || count !== 11'd0) begin
         miscompares++;
         $display("FAIL reject_op err=%b we=%b count=%0d required 1 0 0", err, mem_we, count);
      end
      advance();
      vectors++;
      if (err !== 1'b0 || count !== 11'd0) begin
         miscompares++;
         $display("FAIL reject_after err=%b count=%0d required 0 0", err, count);
      end
      finish = 1'b1; advance(); finish = 1'b0;
   endtask

   task automatic test_full();
      int writes, dones;
      writes = 0; dones = 0;
      start = 1'b1; advance(); start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 5) set_bundle(7'b0010011, 3'($urandom), 7'd0, 5'($urandom), 5'd0, 5'($urandom),
                               32'($urandom_range(0, 4095)) - 32'd2048);
         else in_valid = 1'b0;
         if (i < 5) begin
            vectors++;
            if (in_ready !== (i < 4) || in_ready !== exp_ready()) begin
               miscompares++;
               $display("FAIL full_ready bundle=%0d got %b required %b", i, in_ready, exp_ready());
            end
         end
         advance();
         vectors++;
         if (mem_we !== exp_we || err !== exp_err || done !== exp_done || count !== 11'(m_count) ||
             mem_wdata !== exp_data || (exp_we && mem_addr !== exp_addr)) begin
            miscompares++;
            $display("FAIL full_cycle i=%0d we=%b/%b err=%b/%b done=%b/%b count=%0d/%0d addr=%h/%h data=%h/%h",
                     i, mem_we, exp_we, err, exp_err, done, exp_done, count, m_count,
                     mem_addr, exp_addr, mem_wdata, exp_data);
         end
         if (mem_we === 1'b1) begin
            vectors++;
            if (mem_addr !== BASE + 32'(4 * writes)) begin
               miscompares++;
               $display("FAIL full_addr got %h required %h", mem_addr, BASE + 32'(4 * writes));
            end
            writes++;
         end
         if (done === 1'b1) dones++;
      end
      vectors++;
      if (writes != 4 || dones != 1 || count !== 11'd4) begin
         miscompares++;
         $display("FAIL full_totals writes=%0d dones=%0d count=%0d required 4 1 4", writes, dones, count);
      end
      finish = 1'b1; advance(); finish = 1'b0;
      vectors++;
      if (done !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_exit done=%b in_ready=%b required 0 0", done, in_ready);
      end
   endtask

   task automatic test_finish_accept();
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4, 32'd7);
      finish = 1'b1;
      advance();
      in_valid = 1'b0; finish = 1'b0;
      vectors++;
      if (mem_we !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0 || mem_wdata !== 32'h0071_8213) begin
         miscompares++;
         $display("FAIL finish_accept we=%b done=%b ready=%b data=%h required 1 1 0 00718213",
                  mem_we, done, in_ready, mem_wdata);
      end
      advance();
      vectors++;
      if (count !== 11'd1 || mem_we !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL finish_accept_after count=%0d we=%b done=%b required 1 0 0", count, mem_we, done);
      end
   endtask

   task automatic test_rst_midflight();
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd5);
      rst = 1'b1;
      advance();
      rst = 1'b0; in_valid = 1'b0;
      vectors++;
      if (mem_we !== 1'b0 || count !== 11'd0 || in_ready !== 1'b0 || mem_wdata !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_drop we=%b count=%0d ready=%b data=%h required 0 0 0 0", mem_we, count, in_ready, mem_wdata);
      end
      start = 1'b1; advance(); start = 1'b0;
      set_bundle(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 32'd5);
      advance();
      in_valid = 1'b0;
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== BASE) begin
         miscompares++;
         $display("FAIL rst_resume we=%b addr=%h required 1 %h", mem_we, mem_addr, BASE);
      end
      finish = 1'b1; advance(); finish = 1'b0;
   endtask

   task automatic test_random();
      logic [6:0]  s_op;
      logic [2:0]  s_f3;
      logic [4:0]  s_rs1, s_rs2, s_rd, dreg;
      logic [31:0] s_imm, w, dimm;
      int k;
      for (int cyc = 0; cyc < 400; cyc++) begin
         start  = ($urandom_range(0, 7) == 0);
         finish = ($urandom_range(0, 24) == 0);
         rand_bundle();
         in_valid = ($urandom_range(0, 3) != 0);
         vectors++;
         if (in_ready !== exp_ready()) begin
            miscompares++;
            $display("FAIL rand_ready cyc=%0d got %b required %b", cyc, in_ready, exp_ready());
         end
         if (in_valid && exp_ready()) begin
            s_op = opcode; s_f3 = func3; s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_imm = imm;
         end
         advance();
         vectors++;
         if (mem_we !== exp_we || err !== exp_err || done !== exp_done || count !== 11'(m_count) ||
             mem_wdata !== exp_data || (exp_we && mem_addr !== exp_addr)) begin
            miscompares++;
            $display("FAIL rand_cycle cyc=%0d we=%b/%b err=%b/%b done=%b/%b count=%0d/%0d addr=%h/%h data=%h/%h",
                     cyc, mem_we, exp_we, err, exp_err, done, exp_done, count, m_count,
                     mem_addr, exp_addr, mem_wdata, exp_data);
         end
         k = op_kind(s_op);
         if (exp_we && (k == K_I || k == K_S || k == K_B)) begin
            w = mem_wdata;
            if (k == K_I) begin
               dimm = {{20{w[31]}}, w[31:20]}; dreg = w[11:7];
            end else if (k == K_S) begin
               dimm = {{20{w[31]}}, w[31:25], w[11:7]}; dreg = w[24:20];
            end else begin
               dimm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; dreg = w[24:20];
            end
            vectors++;
            if (dimm !== s_imm || w[19:15] !== s_rs1 || w[14:12] !== s_f3 || w[6:0] !== s_op ||
                dreg !== ((k == K_I) ? s_rd : s_rs2)) begin
               miscompares++;
               $display("FAIL round_trip cyc=%0d word=%h imm=%h/%h rs1=%0d/%0d f3=%0d/%0d reg=%0d",
                        cyc, w, dimm, s_imm, w[19:15], s_rs1, w[14:12], s_f3, dreg);
            end
         end
      end
      start = 1'b0; finish = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_encode_directed();
      test_reject();
      test_full();
      test_finish_accept();
      test_rst_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
